// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding and constants for the lock controller
package lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_START    = 3'd2,
    ST_BLINK    = 3'd3,
    ST_UNLOCKED = 3'd4,
    ST_LOCKOUT  = 3'd5
  } lock_state_e;

  localparam logic BLINK_OK   = 1'b1;
  localparam logic BLINK_FAIL = 1'b0;

  localparam logic [3:0] DIGIT_MIN = 4'd1;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic is_valid_digit(input logic [3:0] d);
    return (d >= DIGIT_MIN) && (d <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// rtl/lock_controller_if.sv - keypad input and blinker handshake bundle
interface lock_controller_if;
  logic [3:0] button;
  logic       bstate;
  logic       done_blinking;
  logic       start_blinking;
  logic       blinkType;

  modport master (
    output button, bstate, done_blinking,
    input  start_blinking, blinkType
  );

  modport slave (
    input  button, bstate, done_blinking,
    output start_blinking, blinkType
  );
endinterface

// File: rtl/key_event_sync.sv
// rtl/key_event_sync.sv - synchronizes keypad signals and flags valid key releases
module key_event_sync
  import lock_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] button,
  input  logic       bstate,
  output logic       key_valid,
  output logic [3:0] key_digit
);

  logic [1:0] bstate_sync;
  logic       bstate_d;
  logic [3:0] button_s1;
  logic [3:0] button_s2;
  logic [3:0] button_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bstate_sync <= 2'b00;
      bstate_d    <= 1'b0;
      button_s1   <= 4'd0;
      button_s2   <= 4'd0;
      button_d    <= 4'd0;
    end else begin
      bstate_sync <= {bstate_sync[0], bstate};
      bstate_d    <= bstate_sync[1];
      button_s1   <= button;
      button_s2   <= button_s1;
      button_d    <= button_s2;
    end
  end

  // button_d is the key value from the last cycle the key was still held
  assign key_digit = button_d;
  assign key_valid = bstate_d & ~bstate_sync[1] & is_valid_digit(button_d);

endmodule

// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - code entry, verification, reprogramming and lockout FSM
module lock_controller
  import lock_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
  parameter int          MAX_FAILS      = 3,
  parameter logic [23:0] LOCKOUT_CYCLES = 24'd12_000_000
) (
  input  logic              hwclk,
  input  logic              rst_n,
  lock_controller_if.slave  bus,
  output logic              unlocked,
  output logic              locked_out,
  output logic [3:0]        digit_count,
  output logic [3:0]        fail_count
);

  localparam int W = 4 * CODE_LEN;

  lock_state_e state;
  logic [W-1:0] entry;
  logic [W-1:0] code;
  logic [W-1:0] entry_shift;
  logic [23:0]  lock_cnt;
  logic         done_prev;
  logic         reprogram;
  logic         start_q;
  logic         blink_q;
  logic         key_valid;
  logic [3:0]   key_digit;
  logic         last_digit;
  logic         done_rise;

  key_event_sync u_sync (
    .clk       (hwclk),
    .rst_n     (rst_n),
    .button    (bus.button),
    .bstate    (bus.bstate),
    .key_valid (key_valid),
    .key_digit (key_digit)
  );

  if (CODE_LEN == 1) begin : g_shift_one
    assign entry_shift = key_digit;
  end else begin : g_shift_multi
    assign entry_shift = {entry[W-5:0], key_digit};
  end

  assign last_digit         = (digit_count == 4'(CODE_LEN - 1));
  assign done_rise          = bus.done_blinking & ~done_prev;
  assign bus.start_blinking = start_q;
  assign bus.blinkType      = blink_q;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ENTRY;
      entry       <= '0;
      code        <= DEFAULT_CODE[W-1:0];
      lock_cnt    <= 24'd0;
      done_prev   <= 1'b0;
      reprogram   <= 1'b0;
      start_q     <= 1'b0;
      blink_q     <= 1'b0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      digit_count <= 4'd0;
      fail_count  <= 4'd0;
    end else begin
      done_prev <= bus.done_blinking;
      start_q   <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (key_valid) begin
            entry       <= entry_shift;
            digit_count <= digit_count + 4'd1;
            if (last_digit) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (entry == code) begin
            fail_count <= 4'd0;
            blink_q    <= BLINK_OK;
          end else begin
            if (fail_count != 4'hF) fail_count <= fail_count + 4'd1;
            blink_q <= BLINK_FAIL;
          end
          digit_count <= 4'd0;
          entry       <= '0;
          state       <= ST_START;
        end
        ST_START: begin
          if (bus.done_blinking) begin
            start_q <= 1'b1;
            state   <= ST_BLINK;
          end
        end
        ST_BLINK: begin
          // done_prev is still high from START, so only a fresh 0->1 completes the blink
          if (done_rise) begin
            if (reprogram) begin
              reprogram <= 1'b0;
              state     <= ST_ENTRY;
            end else if (blink_q == BLINK_OK) begin
              unlocked <= 1'b1;
              state    <= ST_UNLOCKED;
            end else if (fail_count >= 4'(MAX_FAILS)) begin
              locked_out <= 1'b1;
              lock_cnt   <= LOCKOUT_CYCLES;
              state      <= ST_LOCKOUT;
            end else begin
              state <= ST_ENTRY;
            end
          end
        end
        ST_UNLOCKED: begin
          if (key_valid) begin
            if (last_digit) begin
              code        <= entry_shift;
              entry       <= '0;
              digit_count <= 4'd0;
              unlocked    <= 1'b0;
              blink_q     <= BLINK_OK;
              reprogram   <= 1'b1;
              state       <= ST_START;
            end else begin
              entry       <= entry_shift;
              digit_count <= digit_count + 4'd1;
            end
          end
        end
        ST_LOCKOUT: begin
          if (lock_cnt == 24'd0) begin
            locked_out <= 1'b0;
            fail_count <= 4'd0;
            state      <= ST_ENTRY;
          end else begin
            lock_cnt <= lock_cnt - 24'd1;
          end
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - scoreboard bench for lock_controller
module tb_lock_controller;
  localparam logic [23:0] LOCK_L = 24'd20;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       unlocked;
  logic       locked_out;
  logic [3:0] digit_count;
  logic [3:0] fail_count;

  int   total = 0;
  int   bad = 0;
  int   pulse_count = 0;
  logic exp_q[$];
  logic exp_bt;

  lock_controller_if bus();

  lock_controller #(
    .CODE_LEN(4), .DEFAULT_CODE(32'h0000_1234), .MAX_FAILS(3), .LOCKOUT_CYCLES(LOCK_L)
  ) dut (
    .hwclk(hwclk), .rst_n(rst_n), .bus(bus), .unlocked(unlocked),
    .locked_out(locked_out), .digit_count(digit_count), .fail_count(fail_count)
  );

  always #5 hwclk = ~hwclk;

  // Scoreboard: every start pulse must match the next expected blink type
  always @(negedge hwclk) begin
    if (rst_n && bus.start_blinking) begin
      pulse_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL blink_type: unexpected pulse blinkType=%0b, no pulse expected", bus.blinkType);
      end else begin
        exp_bt = exp_q.pop_front();
        if (bus.blinkType !== exp_bt) begin
          bad++;
          $display("FAIL blink_type: got %0b, expected %0b", bus.blinkType, exp_bt);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge hwclk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.button = d;
    bus.bstate = 1'b1;
    idle(3);
    bus.bstate = 1'b0;
    idle(4);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic apply_reset();
    bus.bstate = 1'b0;
    bus.button = 4'd0;
    bus.done_blinking = 1'b1;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic wait_pulse();
    int  start_cnt;
    bit  seen;
    start_cnt = pulse_count;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge hwclk);
      #1;
      if (pulse_count != start_cnt) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL pulse_wait: no start_blinking within 40 cycles, expected one");
    end
  endtask

  task automatic blink_cycle(input bit key_during);
    wait_pulse();
    bus.done_blinking = 1'b0;
    if (key_during) press(4'd5);
    else idle(4);
    bus.done_blinking = 1'b1;
  endtask

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    bus.bstate = 1'b0;
    bus.button = 4'd0;
    bus.done_blinking = 1'b1;
    rst_n = 1'b0;
    idle(3);
    check4("rst_unlocked", {3'b0, unlocked}, 4'd0);
    check4("rst_locked_out", {3'b0, locked_out}, 4'd0);
    check4("rst_digit_count", digit_count, 4'd0);
    check4("rst_fail_count", fail_count, 4'd0);
    check4("rst_start", {3'b0, bus.start_blinking}, 4'd0);
    check4("rst_blinktype", {3'b0, bus.blinkType}, 4'd0);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_unlock();
    apply_reset();
    press(4'd1);
    check4("cnt_after_1", digit_count, 4'd1);
    press(4'd2);
    check4("cnt_after_2", digit_count, 4'd2);
    press(4'd3);
    check4("cnt_after_3", digit_count, 4'd3);
    exp_q.push_back(1'b1);
    press(4'd4);
    check4("cnt_after_check", digit_count, 4'd0);
    blink_cycle(1'b0);
    idle(2);
    check4("unlock_unlocked", {3'b0, unlocked}, 4'd1);
    check4("unlock_fail_count", fail_count, 4'd0);
  endtask

  task automatic test_reprogram();
    exp_q.push_back(1'b1);
    enter_code(16'h9876);
    blink_cycle(1'b0);
    idle(2);
    check4("reprog_relocked", {3'b0, unlocked}, 4'd0);
    exp_q.push_back(1'b0);
    enter_code(16'h1234);
    blink_cycle(1'b0);
    idle(2);
    check4("old_code_fail_count", fail_count, 4'd1);
    check4("old_code_unlocked", {3'b0, unlocked}, 4'd0);
    exp_q.push_back(1'b1);
    enter_code(16'h9876);
    blink_cycle(1'b0);
    idle(2);
    check4("new_code_unlocked", {3'b0, unlocked}, 4'd1);
    check4("new_code_fail_count", fail_count, 4'd0);
    apply_reset();
    exp_q.push_back(1'b1);
    enter_code(16'h1234);
    blink_cycle(1'b0);
    idle(2);
    check4("default_after_reset", {3'b0, unlocked}, 4'd1);
  endtask

  task automatic test_invalid_keys();
    int pc;
    apply_reset();
    pc = pulse_count;
    press(4'd0);
    press(4'd1);
    press(4'd12);
    press(4'd2);
    press(4'd15);
    idle(10);
    check4("invalid_digit_count", digit_count, 4'd2);
    check4("invalid_no_pulse", 4'(pulse_count - pc), 4'd0);
  endtask

  task automatic test_lockout();
    int cnt;
    apply_reset();
    for (int f = 1; f <= 3; f++) begin
      exp_q.push_back(1'b0);
      enter_code(16'h1235);
      check4("lock_fail_step", fail_count, 4'(f));
      blink_cycle(1'b0);
      if (f < 3) idle(2);
    end
    cnt = 0;
    for (int i = 0; i < int'(LOCK_L) + 30; i++) begin
      @(posedge hwclk);
      #1;
      if (locked_out) cnt++;
      else break;
      if (cnt == 3) begin bus.button = 4'd1; bus.bstate = 1'b1; end
      if (cnt == 6) bus.bstate = 1'b0;
      if (cnt == 14) check4("lockout_key_ignored", digit_count, 4'd0);
    end
    total++;
    if (cnt != int'(LOCK_L) + 1) begin
      bad++;
      $display("FAIL lockout_len: got %0d cycles, expected %0d", cnt, int'(LOCK_L) + 1);
    end
    idle(2);
    check4("lockout_fail_cleared", fail_count, 4'd0);
    check4("lockout_released", {3'b0, locked_out}, 4'd0);
    exp_q.push_back(1'b1);
    enter_code(16'h1234);
    blink_cycle(1'b0);
    idle(2);
    check4("post_lockout_unlock", {3'b0, unlocked}, 4'd1);
  endtask

  task automatic test_wait_done();
    int pc;
    apply_reset();
    bus.done_blinking = 1'b0;
    pc = pulse_count;
    exp_q.push_back(1'b1);
    enter_code(16'h1234);
    idle(10);
    check4("held_no_pulse", 4'(pulse_count - pc), 4'd0);
    bus.done_blinking = 1'b1;
    blink_cycle(1'b1);
    idle(3);
    check4("one_pulse_only", 4'(pulse_count - pc), 4'd1);
    check4("blink_keys_dropped", digit_count, 4'd0);
    check4("wait_done_unlocked", {3'b0, unlocked}, 4'd1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    exp_q.push_back(1'b1);
    enter_code(16'h1234);
    wait_pulse();
    bus.done_blinking = 1'b0;
    idle(2);
    #3 rst_n = 1'b0;
    #1;
    check4("midblink_blinktype", {3'b0, bus.blinkType}, 4'd0);
    check4("midblink_unlocked", {3'b0, unlocked}, 4'd0);
    bus.done_blinking = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    for (int f = 1; f <= 3; f++) begin
      exp_q.push_back(1'b0);
      enter_code(16'h1235);
      blink_cycle(1'b0);
      idle(2);
    end
    check4("midlock_active", {3'b0, locked_out}, 4'd1);
    idle(3);
    #3 rst_n = 1'b0;
    #1;
    check4("midlock_locked_out", {3'b0, locked_out}, 4'd0);
    check4("midlock_fail_count", fail_count, 4'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    exp_q.push_back(1'b1);
    enter_code(16'h1234);
    blink_cycle(1'b0);
    idle(2);
    check4("reset_then_default", {3'b0, unlocked}, 4'd1);
  endtask

  initial begin
    bus.button = 4'd0;
    bus.bstate = 1'b0;
    bus.done_blinking = 1'b1;
    idle(1);
    test_reset();
    test_unlock();
    test_reprogram();
    test_invalid_keys();
    test_lockout();
    test_wait_done();
    test_reset_mid();
    idle(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_blinks: %0d expected pulses never seen, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
# lock_controller

Code-entry and verification FSM for the digital lock. Sits directly downstream of the keypad scanner: consumes its `button`/`bstate` pair, assembles a multi-digit code, compares it against a stored code, and drives the LED blinker's start/type handshake to report pass or fail. It also owns the unlocked state, code re-programming and failed-attempt lockout.

## Interface
Parameters:
- `CODE_LEN`, 4: digits per code, 1..8.
- `DEFAULT_CODE`, 32'h0000_1234: reset code, one 4-bit digit per nibble, LSB nibble = last digit; only low `4*CODE_LEN` bits are used.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout, 1..15.
- `LOCKOUT_CYCLES`, 24'd12_000_000: lockout duration in `hwclk` cycles.

Ports:
- `hwclk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `button`  in  4: key code from the keypad scanner; valid digits 1..9.
- `bstate`  in  1: key-held level from the scanner, asynchronous to `hwclk`.
- `done_blinking`  in  1: blinker idle/finished level.
- `start_blinking`  out  1: one-cycle start pulse to the blinker.
- `blinkType`  out  1: 1 = success pattern, 0 = failure pattern; held from pulse until the blink completes.
- `unlocked`  out  1: lock open.
- `locked_out`  out  1: lockout active; all keys ignored.
- `digit_count`  out  4: digits entered in the current attempt.
- `fail_count`  out  4: consecutive failures.

## Operation
- Reset: every output 0; stored code = `DEFAULT_CODE`; state ENTRY.
- `bstate` and `button` pass through a 2-FF synchronizer. A key event is the 1→0 transition (release) of synchronized `bstate`; the digit is the synchronized `button` value held in the cycle before release. Digits 0 and 10..15 are discarded without any state change.
- States:
  - ENTRY: each valid digit is shifted into the entry register and increments `digit_count`. On the `CODE_LEN`-th digit, go to CHECK.
  - CHECK (1 cycle): on match, clear `fail_count` and set `blinkType`=1. On mismatch, increment `fail_count` (saturating at 15) and set `blinkType`=0. Clear `digit_count`, then go to START.
  - START: wait for `done_blinking`=1, then pulse `start_blinking` for 1 cycle and go to BLINK.
  - BLINK: wait for a 0→1 transition of `done_blinking` after the pulse; key events are dropped. When it completes:
    - success: go to UNLOCKED with `unlocked`=1.
    - failure with `fail_count` ≥ `MAX_FAILS`: go to LOCKOUT.
    - other failure: go to ENTRY.
  - UNLOCKED: `CODE_LEN` valid digits become the new stored code. Then `unlocked`=0, `digit_count`=0, `blinkType`=1, and go to START; after the blink, go to ENTRY.
  - LOCKOUT: `locked_out`=1; the counter loads `LOCKOUT_CYCLES` and counts to 0. Then `locked_out`=0, `fail_count`=0, and go to ENTRY.
- Comparison is over the full `4*CODE_LEN` bits; the entry register is cleared whenever `digit_count` returns to 0.
- Reset mid-operation (any state, including mid-blink or mid-lockout) restores the reset values and `DEFAULT_CODE`. A programmed code is not retained.

## Timing
- A digit is counted 3 `hwclk` cycles after `bstate` falls at the pin (2 synchronizer stages + edge register).
- Last digit release → CHECK, 1 cycle → START, 1 cycle → `start_blinking` in the next cycle if `done_blinking`=1.
- `unlocked` rises in the cycle after the `done_blinking` 0→1 edge is sampled.
- A release coinciding with the BLINK exit cycle is dropped.
- Lockout lasts exactly `LOCKOUT_CYCLES`+1 cycles of `locked_out`=1.
- Key events must be spaced ≥ 2 cycles apart (always met by human input).

## Structure
- Shared package `lock_pkg`: state encoding (ENTRY, CHECK, START, BLINK, UNLOCKED, LOCKOUT), the `BLINK_OK`/`BLINK_FAIL` constants, and the valid-digit range constants.
- One sub-module, `key_event_sync`: 2-FF synchronizer for `bstate`/`button`, plus release-edge detection producing `key_valid`/`key_digit`.
- The FSM, entry shift register, code register and lockout counter live in `lock_controller`.

## Test plan
- Press 1,2,3,4 with `done_blinking`=1 → one `start_blinking` pulse with `blinkType`=1. After `done_blinking` goes 0→1, `unlocked`=1 and `fail_count`=0.
- Enter 1,2,3,5 three times → `blinkType`=0 each time and `fail_count` steps 1,2,3. After the third blink, `locked_out`=1 for `LOCKOUT_CYCLES`+1 cycles. Keys during lockout leave `digit_count`=0. The lock then returns to ENTRY with `fail_count`=0.
- While unlocked, enter 9,8,7,6 → relock with a success blink. Entering 1,2,3,4 then fails; entering 9,8,7,6 then unlocks.
- Drive `button`=0 and 12 with `bstate` pulses, interleaved with digits 1,2 → `digit_count` ends at 2 and no blink occurs.
- Complete a code while `done_blinking`=0 → no pulse until `done_blinking`=1, then exactly one pulse. Keys pressed during BLINK are ignored.
- Assert `rst_n` low asynchronously mid-lockout and mid-blink → all outputs 0 immediately, and `DEFAULT_CODE` is accepted afterwards.
